// File: rtl/transmitter_framed.sv
// transmitter_framed: FIFO-fed asynchronous serial transmitter.
// Reads one word per frame from a FIFO and sends it as: start bit, data bits LSB first,
// an optional parity bit and one or two stop bits. dout and re are registered.
// Optional line-break generator compiled in with the TRANSMITTER_BREAK_EN macro.
module transmitter_framed #(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = 32'd8,
  parameter int unsigned PARITY          = 32'd0,
  parameter int unsigned STOP_BITS       = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  empty,
`ifdef TRANSMITTER_BREAK_EN
  input  logic                  brk,
`endif
  output logic                  re,
  output logic                  dout,
  output logic                  busy
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned MAX_BITS   = 13;
  localparam int unsigned IDX_W      = $clog2(MAX_BITS);
  localparam int unsigned FRAME_BITS = 1 + WORD_WIDTH + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(FRAME_BITS - 1);

`ifdef TRANSMITTER_BREAK_EN
  typedef enum logic [2:0] {
    STATE_WAIT,
    STATE_ASSERT_READ_ENABLE,
    STATE_READ_WORD,
    STATE_TRANSMIT_BITS,
    STATE_BREAK
  } state_t;
`else
  typedef enum logic [1:0] {
    STATE_WAIT,
    STATE_ASSERT_READ_ENABLE,
    STATE_READ_WORD,
    STATE_TRANSMIT_BITS
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MAX_BITS-1:0]   shift_q, shift_d;
  logic                  dout_q, dout_d;
  logic                  re_q, re_d;
  logic [MAX_BITS-1:0]   frame;

  // Assemble the full frame from the FIFO word; unused upper bits read as stop level.
  always_comb begin
    frame                 = '1;
    frame[0]              = 1'b0;
    frame[WORD_WIDTH:1]   = din;
    if (PARITY == 1) begin
      frame[WORD_WIDTH+1] = ^din;
    end else if (PARITY == 2) begin
      frame[WORD_WIDTH+1] = ~^din;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    re_d    = 1'b0;
    unique case (state_q)
      STATE_WAIT: begin
        dout_d = 1'b1;
        cnt_d  = '0;
        idx_d  = '0;
`ifdef TRANSMITTER_BREAK_EN
        if (brk) begin
          state_d = STATE_BREAK;
          dout_d  = 1'b0;
        end else
`endif
        if (!empty) begin
          state_d = STATE_ASSERT_READ_ENABLE;
          re_d    = 1'b1;
        end
      end
      STATE_ASSERT_READ_ENABLE: begin
        state_d = STATE_READ_WORD;
      end
      STATE_READ_WORD: begin
        // Start bit goes straight to the line; the rest waits in the shifter.
        dout_d  = frame[0];
        shift_d = {1'b1, frame[MAX_BITS-1:1]};
        cnt_d   = '0;
        idx_d   = '0;
        state_d = STATE_TRANSMIT_BITS;
      end
      STATE_TRANSMIT_BITS: begin
        if (cnt_q == LAST_CYCLE) begin
          cnt_d = '0;
          if (idx_q == LAST_BIT) begin
            state_d = STATE_WAIT;
            dout_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            dout_d  = shift_q[0];
            shift_d = {1'b1, shift_q[MAX_BITS-1:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef TRANSMITTER_BREAK_EN
      STATE_BREAK: begin
        // dout_q low marks the held phase; the first released edge only raises the line,
        // so the high time after release is a full bit period.
        if (brk) begin
          dout_d = 1'b0;
          cnt_d  = '0;
        end else if (!dout_q) begin
          dout_d = 1'b1;
        end else if (cnt_q == LAST_CYCLE) begin
          cnt_d   = '0;
          state_d = STATE_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = STATE_WAIT;
        dout_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b1;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      re_q    <= re_d;
    end
  end

  assign re   = re_q;
  assign dout = dout_q;
  assign busy = (state_q != STATE_WAIT);

endmodule

// File: tb/tb_transmitter_framed.sv
// Testbench for transmitter_framed: four instances (8N1, 8E1, 8O1, 7N2) at default timing.
// Break checks are compiled when TRANSMITTER_BREAK_EN is defined.
module tb_transmitter_framed;

  localparam int BC = 868;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] din_tb;
  logic [3:0] empty_v;
  logic       brk;
  logic [3:0] re_v, dout_v, busy_v;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  transmitter_framed u_dut (
    .clk(clk), .rst_n(rst_n), .din(din_tb[7:0]), .empty(empty_v[0]),
`ifdef TRANSMITTER_BREAK_EN
    .brk(brk),
`endif
    .re(re_v[0]), .dout(dout_v[0]), .busy(busy_v[0])
  );

  transmitter_framed #(.PARITY(32'd1)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din_tb[7:0]), .empty(empty_v[1]),
`ifdef TRANSMITTER_BREAK_EN
    .brk(brk),
`endif
    .re(re_v[1]), .dout(dout_v[1]), .busy(busy_v[1])
  );

  transmitter_framed #(.PARITY(32'd2)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din_tb[7:0]), .empty(empty_v[2]),
`ifdef TRANSMITTER_BREAK_EN
    .brk(brk),
`endif
    .re(re_v[2]), .dout(dout_v[2]), .busy(busy_v[2])
  );

  transmitter_framed #(.WORD_WIDTH(32'd7), .STOP_BITS(32'd2)) u_w7s2 (
    .clk(clk), .rst_n(rst_n), .din(din_tb[6:0]), .empty(empty_v[3]),
`ifdef TRANSMITTER_BREAK_EN
    .brk(brk),
`endif
    .re(re_v[3]), .dout(dout_v[3]), .busy(busy_v[3])
  );

  typedef struct {
    int          sel;
    logic [8:0]  din;
    int          nbits;
    logic [12:0] exp;   // expected line bits, bit 0 sent first
    string       tag;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first transmit cycle (start bit on the line).
  task automatic start_frame(input int sel, input logic [8:0] d, input bit hold);
    empty_v[sel] = 1'b0;
    step();
    chk("re_assert", re_v[sel], 1'b1);
    chk("busy_assert", busy_v[sel], 1'b1);
    din_tb = d;
    if (!hold) empty_v[sel] = 1'b1;
    step();
    chk("re_one_cycle", re_v[sel], 1'b0);
    step();
  endtask

  // Samples every bit mid-period and checks busy falls exactly at the frame end.
  task automatic check_bits(input int sel, input int nbits, input logic [12:0] exp,
                            input string tag);
    bit re_seen = 1'b0;
    for (int t = 0; t < nbits * BC; t++) begin
      if (t % BC == BC / 2)
        chk($sformatf("%s_bit%0d", tag, t / BC), dout_v[sel], exp[t / BC]);
      if (re_v[sel]) re_seen = 1'b1;
      if (t == nbits * BC - 1) chk({tag, "_busy_last"}, busy_v[sel], 1'b1);
      step();
    end
    chk({tag, "_busy_end"}, busy_v[sel], 1'b0);
    chk({tag, "_dout_end"}, dout_v[sel], 1'b1);
    chk({tag, "_re_end"}, re_v[sel], 1'b0);
    chk({tag, "_no_re_in_frame"}, re_seen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad;
    vecs[0] = '{sel: 0, din: 9'h0A5, nbits: 10, exp: 13'b1101001010,  tag: "8n1_a5"};
    vecs[1] = '{sel: 1, din: 9'h0A5, nbits: 11, exp: 13'b10101001010, tag: "8e1_a5"};
    vecs[2] = '{sel: 2, din: 9'h0A5, nbits: 11, exp: 13'b11101001010, tag: "8o1_a5"};
    vecs[3] = '{sel: 3, din: 9'h041, nbits: 10, exp: 13'b1110000010,  tag: "7n2_41"};

    empty_v = '1;
    din_tb  = '0;
    brk     = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset_dout%0d", s), dout_v[s], 1'b1);
      chk($sformatf("reset_re%0d", s), re_v[s], 1'b0);
      chk($sformatf("reset_busy%0d", s), busy_v[s], 1'b0);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_empty_busy", busy_v[0], 1'b0);
    chk("idle_empty_re", re_v[0], 1'b0);

    foreach (vecs[i]) begin
      start_frame(vecs[i].sel, vecs[i].din, 1'b0);
      check_bits(vecs[i].sel, vecs[i].nbits, vecs[i].exp, vecs[i].tag);
      step();
    end

    // Back-to-back: empty held low, second re right after the single wait cycle.
    start_frame(0, 9'h0A5, 1'b1);
    check_bits(0, 10, 13'b1101001010, "b2b_first");
    start_frame(0, 9'h03C, 1'b0);
    check_bits(0, 10, 13'b1001111000, "b2b_second");
    step();

    // Reset during the third data bit of an all-zero word.
    start_frame(0, 9'h000, 1'b0);
    repeat (3 * BC + 100) step();
    chk("pre_reset_dout", dout_v[0], 1'b0);
    chk("pre_reset_busy", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_dout", dout_v[0], 1'b1);
    chk("async_reset_re", re_v[0], 1'b0);
    chk("async_reset_busy", busy_v[0], 1'b0);
    step();
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int t = 0; t < 3 * BC; t++) begin
      if (dout_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || re_v[0] !== 1'b0) bad = 1'b1;
      step();
    end
    chk("no_residual_bits", bad, 1'b0);
    empty_v[0] = 1'b0;
    step();
    chk("first_re_after_reset", re_v[0], 1'b1);
    empty_v[0] = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef TRANSMITTER_BREAK_EN
    brk        = 1'b1;
    empty_v[0] = 1'b0;
    step();
    chk("brk_dout_low", dout_v[0], 1'b0);
    chk("brk_busy", busy_v[0], 1'b1);
    chk("brk_priority_re", re_v[0], 1'b0);
    bad = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (dout_v[0] !== 1'b0 || re_v[0] !== 1'b0 || busy_v[0] !== 1'b1) bad = 1'b1;
      step();
    end
    chk("brk_hold_low", bad, 1'b0);
    brk = 1'b0;
    step();
    bad = 1'b0;
    for (int t = 0; t < BC; t++) begin
      if (dout_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || re_v[0] !== 1'b0) bad = 1'b1;
      step();
    end
    chk("brk_release_high", bad, 1'b0);
    chk("brk_wait_busy", busy_v[0], 1'b0);
    chk("brk_wait_re", re_v[0], 1'b0);
    step();
    chk("brk_queued_re", re_v[0], 1'b1);
    empty_v[0] = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
